// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: state encoding and counter sizing shared by the serial arithmetic blocks
package serial_subtractor_pkg;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN = 1'b1;
  function automatic int cnt_w(input int width);
    return $clog2(width) + 1;
  endfunction
endpackage

// File: rtl/serial_subtractor_fullsubtractor.sv
// fullsubtractor: gate-level one-bit full subtractor cell, diff = a - b - bin
module fullsubtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);
  logic axb;
  assign axb = a ^ b;
  assign diff = axb ^ bin;
  assign bout = (~a & b) | (~axb & bin);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial LSB-first x - y - bi with start/ready/done handshake
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bi,
  output logic             ready,
  output logic [WIDTH-1:0] d,
  output logic             bo,
  output logic             done
);
  localparam int CNT_W = cnt_w(WIDTH);
  logic [0:0] state;
  logic [WIDTH-1:0] xs, ys;
  logic [WIDTH-2:0] rs;
  logic [CNT_W-1:0] cnt;
  logic borrow, dbit, nb;
  fullsubtractor u_fs (
    .a(xs[0]),
    .b(ys[0]),
    .bin(borrow),
    .diff(dbit),
    .bout(nb)
  );
  assign ready = (state == IDLE);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      xs <= '0;
      ys <= '0;
      rs <= '0;
      cnt <= '0;
      borrow <= 1'b0;
      d <= '0;
      bo <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          xs <= x;
          ys <= y;
          borrow <= bi;
          cnt <= '0;
          state <= RUN;
        end
      end else begin
        xs <= xs >> 1;
        ys <= ys >> 1;
        rs <= (WIDTH-1)'({dbit, rs} >> 1);
        borrow <= nb;
        cnt <= cnt + 1'b1;
        if (cnt == CNT_W'(WIDTH - 1)) begin
          d <= {dbit, rs};
          bo <= nb;
          done <= 1'b1;
          state <= IDLE;
        end
      end
    end
  end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor: computes d = x - y - bi, LSB first, one bit per clock.
- Uses a single registered full-subtractor cell. It is the subtraction counterpart of the team's combinational ripple adder.
- Serves area-constrained datapaths (accumulators, comparators) that can tolerate WIDTH-cycle latency.
- Start/ready/done handshake to the controlling FSM.

Parameters:
- WIDTH, 4, operand and result width in bits (>=2).
- CNT_W, $clog2(WIDTH)+1, bit counter width (derived; not overridden).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when ready=1.
- x  input  WIDTH  minuend; sampled with start.
- y  input  WIDTH  subtrahend; sampled with start.
- bi  input  1  borrow-in; sampled with start.
- ready  output  1  high when a new start will be accepted.
- d  output  WIDTH  difference; registered, held until the next completion.
- bo  output  1  borrow-out (1 = x < y + bi unsigned); registered, held.
- done  output  1  one-cycle pulse when d/bo have been updated.

Behaviour:
- Clock and reset are fixed: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: ready=1, d=0, bo=0, done=0, state=IDLE, counter=0, shift registers=0.
- FSM has two states, IDLE and RUN.
- IDLE:
  - ready=1.
  - On a clock edge with start=1: load xs<=x, ys<=y, borrow<=bi, cnt<=0, then go to RUN.
  - start=0: stay in IDLE.
- RUN:
  - ready=0.
  - Each edge: diff bit = xs[0]^ys[0]^borrow; borrow <= (~xs[0]&ys[0]) | (~(xs[0]^ys[0])&borrow).
  - Diff bit shifts into the MSB of the result shift register rs. xs and ys shift right. cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1 (the WIDTH-th shift):
    - d <= {diff bit, rs[WIDTH-1:1]}, bo <= new borrow, done <= 1.
    - Go to IDLE.
- Latency: if start is sampled at edge E, done, d and bo are valid after edge E+WIDTH (high during cycle E+WIDTH..E+WIDTH+1).
- done is high for exactly one cycle.
- ready rises in the same cycle as done, so a start presented during the done cycle is accepted (back-to-back; throughput is one operation per WIDTH cycles).
- start while ready=0 is ignored, with no effect on the in-flight operation. x, y and bi may change freely after acceptance.
- d and bo change only on a done edge or on reset. They are never visible mid-computation.
- Arithmetic is modulo 2^WIDTH: d = (x - y - bi) mod 2^WIDTH; bo = (x < y + bi).
- Reset mid-RUN: abort the operation, return to IDLE with reset values, no done pulse. d is cleared to 0.
- Reset and start in the same cycle: reset wins.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=1'b0, RUN=1'b1.
  - a CNT_W helper function, so sibling serial arithmetic blocks (serial adder, serial comparator) share the encoding.
- One natural sub-module: fullsubtractor (a, b, bin -> diff, bout), purely combinational, gate-level. It mirrors the existing full-adder cell and is instantiated once.

Test Plan:
- Reset then x=0011, y=0001, bi=0, start=1 for one cycle -> ready low for 4 cycles; after 4 edges done=1 for one cycle, d=0010, bo=0, ready=1.
- x=0001, y=0010, bi=0 -> d=1111, bo=1. Also x=0000, y=0000, bi=1 -> d=1111, bo=1 (borrow-in propagates through all bits).
- x=1111, y=1111, bi=0 -> d=0000, bo=0. x=1000, y=0001, bi=0 -> d=0111, bo=0.
- Start pulsed again with x=0000, y=0001 two cycles into an operation on 0101-0011 -> ignored; done shows d=0010, bo=0. Then start held high in the done cycle with 0100-0100 -> accepted, next done d=0000, bo=0.
- rst asserted 2 cycles into an operation -> next cycle ready=1, d=0000, bo=0; no done pulse ever appears for the aborted operation.
- Randomised sweep of all 512 (x, y, bi) combinations for WIDTH=4 -> d and bo match the (x - y - bi) mod 16 and borrow model at every done.
